ledger_line_renderer: RTL and testbench

Pixel-side reader for the staff/ledger-line tile layer. For each screen pixel from the VGA controller it computes the 8x8 tile under that pixel, fetches the tile code from the staff tile map (synchronous RAM), looks up the glyph row in the ledger glyph ROM and emits one on/off pixel bit. It sits between the VGA controller and the colour mapper, with a fixed 3-stage pipeline and a per-frame horizontal scroll offset.

---
 rtl/ledger_line_renderer_pkg.sv | 26 ++
 rtl/ledger_line_renderer_scroll_wrap.sv | 33 +++
 rtl/ledger_line_renderer.sv | 146 ++++++++++++++
 tb/tb_ledger_line_renderer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledger_line_renderer_pkg.sv
// ledger_line_renderer_pkg
// Shared definitions for the staff/ledger-line tile layer: tile code enum,
// screen/tile geometry and the tile-map address helper.
// No ports (package).
package ledger_line_renderer_pkg;

   typedef enum logic [1:0] {
      BLANK  = 2'd0,  // no line
      MIDDLE = 2'd1,  // line on glyph row 4
      ABOVE  = 2'd2,  // line on glyph row 0
      BELOW  = 2'd3   // line on glyph row 7
   } tile_code_e;

   localparam int unsigned TILE_SIZE = 8;
   localparam int unsigned H_TILES   = 80;
   localparam int unsigned V_TILES   = 60;
   localparam int unsigned H_PIXELS  = H_TILES * TILE_SIZE;  // also the scroll wrap modulus
   localparam int unsigned V_PIXELS  = V_TILES * TILE_SIZE;
   localparam int unsigned MAP_AW    = 13;

   // Row-major tile-map index: ty*H_TILES + tx.
   function automatic logic [MAP_AW-1:0] map_index(input logic [5:0] ty, input logic [6:0] tx);
      return MAP_AW'(ty) * MAP_AW'(H_TILES) + MAP_AW'(tx);
   endfunction

endpackage

// File: rtl/ledger_line_renderer_scroll_wrap.sv
// ledger_line_renderer_scroll_wrap
// Combinational horizontal scroll: sx = (drawx + scroll) wrapped once modulo
// H_PIXELS, split into tile column and in-tile pixel column.
// Ports:
//   drawx  in  10  screen pixel column
//   scroll in  10  current scroll offset (always < H_PIXELS)
//   tx     out  7  tile column of the scrolled pixel
//   xin    out  3  pixel column inside the tile
module ledger_line_renderer_scroll_wrap
   import ledger_line_renderer_pkg::*;
(
   input  logic [9:0] drawx,
   input  logic [9:0] scroll,
   output logic [6:0] tx,
   output logic [2:0] xin
);

   logic [10:0] sum;
   logic [9:0]  sx;

   // A single subtract suffices for visible pixels since both operands are < H_PIXELS.
   always_comb begin
      sum = {1'b0, drawx} + {1'b0, scroll};
      sx  = sum[9:0];
      if (sum >= 11'(H_PIXELS)) begin
         sx = 10'(sum - 11'(H_PIXELS));
      end
   end

   assign tx  = sx[9:3];
   assign xin = sx[2:0];

endmodule

// File: rtl/ledger_line_renderer.sv
// ledger_line_renderer
// Pixel-side reader for the staff/ledger-line tile layer. Three-stage pipeline:
//   edge N   : scroll + tile-map address, visibility
//   edge N+1 : tile map returns code (external sync RAM), glyph_addr driven
//   edge N+2 : glyph bit registered onto pixel_on / pixel_valid
// Optional feature macro: LEDGER_CURSOR_EN (adds cursor_col and a 32-frame blink
// that inverts the highlighted tile column).
// Ports:
//   Clk, Reset (async, active-high)
//   DrawX, DrawY, de      pixel position and display enable from the VGA controller
//   frame_start, scroll_in per-frame scroll load (values >= H_PIXELS ignored)
//   map_addr / map_code    tile-map RAM read port (code one cycle after address)
//   glyph_addr / glyph_data combinational glyph ROM port (bit 7 = leftmost pixel)
//   pixel_on, pixel_valid  output pixel and its visibility
//   cursor_col             highlighted tile column (LEDGER_CURSOR_EN only)
module ledger_line_renderer
   import ledger_line_renderer_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              de,
   input  logic              frame_start,
   input  logic [9:0]        scroll_in,
   output logic [MAP_AW-1:0] map_addr,
   input  logic [1:0]        map_code,
   output logic [4:0]        glyph_addr,
   input  logic [7:0]        glyph_data,
   output logic              pixel_on,
   output logic              pixel_valid
`ifdef LEDGER_CURSOR_EN
   ,
   input  logic [6:0]        cursor_col
`endif
);

   logic [9:0]        scroll_q;
   logic [6:0]        tx;
   logic [2:0]        xin;
   logic              vis;
   logic [MAP_AW-1:0] map_addr_d, map_addr_q;
   logic [2:0]        xin_s1_q, yin_s1_q, xin_s2_q, yin_s2_q;
   logic              vis_s1_q, vis_s2_q;
   logic              pixel_on_d, pixel_on_q, pixel_valid_q;
   logic              cursor_hit;
   tile_code_e        code;

   ledger_line_renderer_scroll_wrap u_scroll_wrap (
      .drawx  (DrawX),
      .scroll (scroll_q),
      .tx     (tx),
      .xin    (xin)
   );

   // Scroll is per-frame; the pixel sampled on the frame_start edge still uses the old value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         scroll_q <= '0;
      end else if (frame_start && (scroll_in < 10'(H_PIXELS))) begin
         scroll_q <= scroll_in;
      end
   end

   // Stage 1: visibility and tile-map address; invisible pixels park the address at 0.
   always_comb begin
      vis        = de && (DrawX < 10'(H_PIXELS)) && (DrawY < 10'(V_PIXELS));
      map_addr_d = '0;
      if (vis) begin
         map_addr_d = map_index(DrawY[8:3], tx);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         map_addr_q <= '0;
         xin_s1_q   <= '0;
         yin_s1_q   <= '0;
         vis_s1_q   <= 1'b0;
         xin_s2_q   <= '0;
         yin_s2_q   <= '0;
         vis_s2_q   <= 1'b0;
      end else begin
         map_addr_q <= map_addr_d;
         xin_s1_q   <= xin;
         yin_s1_q   <= DrawY[2:0];
         vis_s1_q   <= vis;
         // Stage 2: align with map_code coming back from the tile-map RAM.
         xin_s2_q   <= xin_s1_q;
         yin_s2_q   <= yin_s1_q;
         vis_s2_q   <= vis_s1_q;
      end
   end

   assign map_addr   = map_addr_q;
   assign code       = tile_code_e'(map_code);
   assign glyph_addr = {code, yin_s2_q};

`ifdef LEDGER_CURSOR_EN
   logic [6:0] tx_s1_q, tx_s2_q;
   logic [4:0] frame_cnt_q;
   logic       blink_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tx_s1_q     <= '0;
         tx_s2_q     <= '0;
         frame_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         tx_s1_q <= tx;
         tx_s2_q <= tx_s1_q;
         if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
            // Phase flips when the counter wraps, i.e. every 32 frames.
            if (frame_cnt_q == 5'd31) begin
               blink_q <= ~blink_q;
            end
         end
      end
   end

   assign cursor_hit = blink_q && (tx_s2_q == cursor_col);
`else
   assign cursor_hit = 1'b0;
`endif

   // Stage 3: pick the glyph bit (bit 7 is the leftmost pixel of the row).
   always_comb begin
      pixel_on_d = vis_s2_q && (glyph_data[3'd7 - xin_s2_q] ^ cursor_hit);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pixel_on_q    <= 1'b0;
         pixel_valid_q <= 1'b0;
      end else begin
         pixel_on_q    <= pixel_on_d;
         pixel_valid_q <= vis_s2_q;
      end
   end

   assign pixel_on    = pixel_on_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_ledger_line_renderer.sv
// tb_ledger_line_renderer
// Bench for ledger_line_renderer: tile-map RAM and glyph ROM models, a
// behavioural pixel model checked every cycle, directed probes with literal
// expectations, and randomized pixels/scroll. Honours LEDGER_CURSOR_EN.
module tb_ledger_line_renderer;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  DrawX, DrawY, scroll_in;
   logic        de, frame_start;
   logic [12:0] map_addr;
   logic [1:0]  map_code;
   logic [4:0]  glyph_addr;
   logic [7:0]  glyph_data;
   logic        pixel_on, pixel_valid;
`ifdef LEDGER_CURSOR_EN
   logic [6:0]  cursor_col = 7'd3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] tile_map [0:8191];

   always #5 clk = ~clk;

   ledger_line_renderer dut (
      .Clk         (clk),
      .Reset       (rst),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .de          (de),
      .frame_start (frame_start),
      .scroll_in   (scroll_in),
      .map_addr    (map_addr),
      .map_code    (map_code),
      .glyph_addr  (glyph_addr),
      .glyph_data  (glyph_data),
      .pixel_on    (pixel_on),
      .pixel_valid (pixel_valid)
`ifdef LEDGER_CURSOR_EN
      ,
      .cursor_col  (cursor_col)
`endif
   );

   // Environment: synchronous tile-map RAM and combinational glyph ROM.
   always @(posedge clk) map_code <= tile_map[map_addr];

   function automatic logic [7:0] glyph_rom(input logic [4:0] a);
      case (a)
         5'b01_100, 5'b10_000, 5'b11_111: return 8'hFF;
         default:                         return 8'h00;
      endcase
   endfunction
   assign glyph_data = glyph_rom(glyph_addr);

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: which glyph row each tile code lights.
   function automatic bit lit(input int code, input int row);
      case (code)
         1:       return row == 4;
         2:       return row == 0;
         3:       return row == 7;
         default: return 1'b0;
      endcase
   endfunction

   typedef struct {
      bit vis;
      bit on;
      int tx;
      int addr;
   } ent_t;

   ent_t pipe [3];
   int   m_scroll = 0;
   int   m_cnt    = 0;
   bit   m_phase  = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      ent_t e;
      int   sx;
      if (rst) begin
         for (int i = 0; i < 3; i++) pipe[i] = '{vis: 1'b0, on: 1'b0, tx: 0, addr: 0};
         m_scroll = 0;
         m_cnt    = 0;
         m_phase  = 1'b0;
      end else begin
         sx = int'(DrawX) + m_scroll;
         if (sx >= 640) sx -= 640;
         e.vis  = de && (DrawX < 640) && (DrawY < 480);
         e.tx   = sx / 8;
         e.addr = e.vis ? (int'(DrawY) / 8) * 80 + e.tx : 0;
         e.on   = e.vis && lit(e.vis ? int'(tile_map[e.addr]) : 0, int'(DrawY) % 8);
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e;
`ifdef LEDGER_CURSOR_EN
         if (pipe[2].vis && m_phase && pipe[2].tx == int'(cursor_col)) pipe[2].on = !pipe[2].on;
`endif
         if (frame_start) begin
            m_cnt++;
            if (m_cnt == 32) begin
               m_cnt   = 0;
               m_phase = !m_phase;
            end
            if (scroll_in < 640) m_scroll = int'(scroll_in);
         end
      end
   end

   // Compare process: outputs settle after the rising edge, sampled on the falling edge.
   always @(negedge clk) begin
      check("model_pixel_valid", int'(pixel_valid), int'(pipe[2].vis));
      check("model_pixel_on", int'(pixel_on), int'(pipe[2].on));
      check("model_map_addr", int'(map_addr), pipe[0].addr);
   end

   task automatic idle(input int n);
      @(negedge clk);
      de          = 1'b0;
      frame_start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic load_scroll(input int s);
      @(negedge clk);
      de          = 1'b0;
      frame_start = 1'b1;
      scroll_in   = 10'(s);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // One isolated pixel: map_addr after 1 edge, pixel after 3 edges.
   task automatic probe(input int x, input int y, input bit d, input bit exp_on,
                        input int exp_addr, input string nm);
      @(negedge clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      de    = d;
      @(posedge clk);
      #1;
      check({nm, "_addr"}, int'(map_addr), exp_addr);
      de = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check({nm, "_on"}, int'(pixel_on), int'(exp_on));
      check({nm, "_valid"}, int'(pixel_valid), int'(exp_addr >= 0 && d && x < 640 && y < 480));
   endtask

   task automatic clear_map(input int code);
      for (int i = 0; i < 8192; i++) tile_map[i] = 2'(code);
   endtask

   initial begin
      rst         = 1'b1;
      DrawX       = '0;
      DrawY       = '0;
      de          = 1'b0;
      frame_start = 1'b0;
      scroll_in   = '0;
      clear_map(0);
      repeat (3) @(negedge clk);
      check("reset_pixel_on", int'(pixel_on), 0);
      check("reset_pixel_valid", int'(pixel_valid), 0);
      check("reset_map_addr", int'(map_addr), 0);
      rst = 1'b0;

      // Blank map, raster sweep with random de gaps: nothing lit.
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 660; x++) begin
            @(negedge clk);
            DrawX = 10'(x);
            DrawY = 10'(y * 9);
            de    = ($urandom_range(0, 9) != 0);
         end
      end

      // Single MIDDLE tile at (5,2).
      idle(3);
      tile_map[165] = 2'd1;
      for (int x = 38; x < 50; x++) probe(x, 20, 1'b1, (x >= 40 && x <= 47), 2 * 80 + x / 8, "mid_tile");
      probe(44, 21, 1'b1, 1'b0, 165, "mid_row21");

      // Scroll by 4 with an ABOVE tile at (0,0).
      idle(3);
      tile_map[165] = 2'd0;
      tile_map[0]   = 2'd2;
      load_scroll(4);
      probe(636, 0, 1'b1, 1'b1, 0, "scr4_x636");
      probe(639, 0, 1'b1, 1'b1, 0, "scr4_x639");
      probe(3, 0, 1'b1, 1'b1, 0, "scr4_x3");
      probe(4, 0, 1'b1, 1'b0, 1, "scr4_x4");
      probe(635, 0, 1'b1, 1'b0, 79, "scr4_x635");
      load_scroll(700);
      probe(636, 0, 1'b1, 1'b1, 0, "scr700_hold");
      load_scroll(1);
      probe(639, 0, 1'b1, 1'b1, 0, "wrap_x639");
      probe(638, 0, 1'b1, 1'b0, 79, "wrap_x638");
      load_scroll(0);

      // BELOW tiles everywhere: invisible pixels stay dark.
      idle(3);
      clear_map(3);
      probe(700, 7, 1'b1, 1'b0, 0, "inv_x700");
      probe(10, 7, 1'b0, 1'b0, 0, "inv_de0");
      probe(10, 500, 1'b1, 1'b0, 0, "inv_y500");
      probe(10, 7, 1'b1, 1'b1, 1, "vis_row7");

      // Reset in the middle of a lit line.
      @(negedge clk);
      DrawY = 10'd7;
      de    = 1'b1;
      for (int x = 0; x < 6; x++) begin
         DrawX = 10'(x);
         @(negedge clk);
      end
      check("pre_reset_valid", int'(pixel_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_reset_on", int'(pixel_on), 0);
      check("mid_reset_valid", int'(pixel_valid), 0);
      check("mid_reset_addr", int'(map_addr), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         check("post_reset_valid", int'(pixel_valid), int'(e == 3));
      end

      // Randomized pixels, frame starts and scroll requests over a random map.
      idle(3);
      for (int i = 0; i < 5120; i++) tile_map[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         DrawX       = 10'($urandom_range(0, 700));
         DrawY       = 10'($urandom_range(0, 520));
         de          = ($urandom_range(0, 4) != 0);
         frame_start = ($urandom_range(0, 19) == 0);
         scroll_in   = 10'($urandom_range(0, 800));
      end

`ifdef LEDGER_CURSOR_EN
      // Cursor blink: phase 1 after 32 frames, back to 0 after 64.
      idle(3);
      clear_map(0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      scroll_in = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         frame_start = 1'b1;
         repeat (32) @(negedge clk);
         frame_start = 1'b0;
         probe(24, 0, 1'b1, k == 0, 3, "cursor_x24");
         probe(31, 0, 1'b1, k == 0, 3, "cursor_x31");
         probe(32, 0, 1'b1, 1'b0, 4, "cursor_x32");
      end
`endif

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
